// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined MIPS32 immediate generator behind a
// valid/ready handshake, with a 2-entry skid buffer (main reg M + skid reg S).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_imm, in_mode     raw immediate and mode (00 sign, 01 zero, 10 upper, 11 branch)
//   out_valid/out_ready downstream handshake
//   out_data, out_mode  extended immediate and the mode that produced it
//   stat_xfers, stat_stalls  transfer / stall counters (IMM_EXT_STATS_EN only)
//
// Optional feature macro: IMM_EXT_STATS_EN
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [31:0]      stat_xfers,
  output logic [31:0]      stat_stalls
`endif
);

  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_extend_pipe: OUT_W must be at least IN_W + 2");
  end
  if (IN_W < 3) begin : g_bad_in_w
    $error("imm_extend_pipe: IN_W must be at least 3");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] res;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   res = sext;
      2'b01:   res = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b10:   res = {imm, {(OUT_W-IN_W){1'b0}}};
      default: res = {sext[OUT_W-3:0], 2'b00};
    endcase
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic [1:0]       m_mode_q, m_mode_d;
  logic [OUT_W-1:0] s_data_q, s_data_d;
  logic [1:0]       s_mode_q, s_mode_d;
  logic             in_ready_q, in_ready_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [OUT_W-1:0] ext_data;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_data_q;
  assign out_mode  = m_mode_q;
  assign in_ready  = in_ready_q;

  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;
  assign ext_data  = extend(in_imm, in_mode);

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_mode_d = m_mode_q;
    s_data_d = s_data_q;
    s_mode_d = s_mode_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          m_data_d = ext_data;
          m_mode_d = in_mode;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          m_data_d = ext_data;
          m_mode_d = in_mode;
        end else if (in_xfer) begin
          s_data_d = ext_data;
          s_mode_d = in_mode;
          state_d  = FULL;
        end else if (out_xfer) begin
          state_d  = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          m_data_d = s_data_q;
          m_mode_d = s_mode_q;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered ready: derived from the next state so it never follows
    // out_ready combinationally.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      m_data_q   <= '0;
      m_mode_q   <= '0;
      s_data_q   <= '0;
      s_mode_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      m_mode_q   <= m_mode_d;
      s_data_q   <= s_data_d;
      s_mode_q   <= s_mode_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef IMM_EXT_STATS_EN
  logic [31:0] stat_xfers_q, stat_xfers_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_xfers_d  = stat_xfers_q;
    stat_stalls_d = stat_stalls_q;
    if (out_xfer) begin
      stat_xfers_d = stat_xfers_q + 32'd1;
    end
    if (out_valid && !out_ready) begin
      stat_stalls_d = stat_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_xfers_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_xfers_q  <= stat_xfers_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_xfers  = stat_xfers_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (IN_W=16, OUT_W=32).
// Stats checks are compiled when IMM_EXT_STATS_EN is defined.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
`ifdef IMM_EXT_STATS_EN
  logic [31:0] stat_xfers;
  logic [31:0] stat_stalls;
`endif

  int checks = 0;
  int errors = 0;
  logic [33:0] sb_q[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(
    .IN_W (16),
    .OUT_W(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode)
`ifdef IMM_EXT_STATS_EN
    ,
    .stat_xfers (stat_xfers),
    .stat_stalls(stat_stalls)
`endif
  );

  // Reference extension computed with integer arithmetic.
  function automatic logic [33:0] model(input logic [15:0] imm, input logic [1:0] mode);
    int          s;
    logic [31:0] r;
    s = int'($signed(imm));
    case (mode)
      2'd0:    r = s;
      2'd1:    r = {16'h0000, imm};
      2'd2:    r = 32'(imm) << 16;
      default: r = s * 4;
    endcase
    return {mode, r};
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    tick();
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_imm    = 16'h1234;
    in_mode   = 2'd0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++;
    if (out_mode !== 2'd0) begin errors++; $display("FAIL reset_out_mode got %0d want 0", out_mode); end
    reset    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_sign_extend();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_imm    = 16'h8001;
    in_mode   = 2'd0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL sext_out_valid got %0b want 1", out_valid); end
    checks++;
    if (out_data !== 32'hFFFF8001) begin errors++; $display("FAIL sext_out_data got %h want ffff8001", out_data); end
    checks++;
    if (out_mode !== 2'd0) begin errors++; $display("FAIL sext_out_mode got %0d want 0", out_mode); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL sext_in_ready got %0b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL sext_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] imms[4];
    logic [1:0]  modes[4];
    logic [31:0] exps[4];
    logic [33:0] e;
    imms  = '{16'h8001, 16'h1234, 16'hFFFF, 16'h4000};
    modes = '{2'd1, 2'd2, 2'd3, 2'd3};
    exps  = '{32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h00010000};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        in_valid = 1'b1;
        in_imm   = imms[k];
        in_mode  = modes[k];
      end else begin
        in_valid = 1'b0;
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exps[k-1]) begin
          errors++;
          $display("FAIL b2b_data[%0d] got v=%0b %h want v=1 %h", k - 1, out_valid, out_data, exps[k-1]);
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %0b want 1", k, in_ready); end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_sb_extra got %h want none", out_data);
        end else begin
          e = sb_q.pop_front();
          if ({out_mode, out_data} !== e) begin
            errors++;
            $display("FAIL b2b_sb got %0d/%h want %0d/%h", out_mode, out_data, e[33:32], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_imm, in_mode));
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end got v=%0b q=%0d want v=0 q=0", out_valid, sb_q.size());
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 16'h0005;
    in_mode   = 2'd0;
    tick();
    in_imm = 16'h0006;
    checks++;
    if (in_ready !== 1'b1 || out_data !== 32'h5) begin
      errors++;
      $display("FAIL stall_a got rdy=%0b %h want rdy=1 00000005", in_ready, out_data);
    end
    tick();
    in_imm = 16'h0007;  // must be ignored while full
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h5) begin
        errors++;
        $display("FAIL stall_hold[%0d] got rdy=%0b v=%0b %h want rdy=0 v=1 00000005", c, in_ready, out_valid, out_data);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_data !== 32'h5) begin errors++; $display("FAIL stall_first got %h want 00000005", out_data); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h6) begin
      errors++;
      $display("FAIL stall_second got v=%0b %h want v=1 00000006", out_valid, out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back got %0b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_third_ignored got v=%0b %h want v=0", out_valid, out_data); end
  endtask

  task automatic test_random();
    logic        prev_stall;
    logic [33:0] prev_out;
    logic [33:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom());
      in_mode   = 2'($urandom_range(0, 3));
      checks++;
      if (out_valid !== (sb_q.size() != 0) || in_ready !== (sb_q.size() < 2)) begin
        errors++;
        $display("FAIL rnd_occupancy[%0d] got v=%0b rdy=%0b want q=%0d", c, out_valid, in_ready, sb_q.size());
      end
      if (prev_stall) begin
        checks++;
        if ({out_mode, out_data} !== prev_out) begin
          errors++;
          $display("FAIL rnd_stable[%0d] got %0d/%h want %0d/%h", c, out_mode, out_data, prev_out[33:32], prev_out[31:0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra[%0d] got %h want none", c, out_data);
        end else begin
          e = sb_q.pop_front();
          if ({out_mode, out_data} !== e) begin
            errors++;
            $display("FAIL rnd_data[%0d] got %0d/%h want %0d/%h", c, out_mode, out_data, e[33:32], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_imm, in_mode));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_mode, out_data};
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({out_mode, out_data} !== e) begin
          errors++;
          $display("FAIL rnd_drain got %0d/%h want %0d/%h", out_mode, out_data, e[33:32], e[31:0]);
        end
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_end got v=%0b q=%0d want v=0 q=0", out_valid, sb_q.size());
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd1;
    in_imm    = 16'h1111;
    tick();
    in_imm = 16'h2222;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_is_full got rdy=%0b want 0", in_ready); end
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_mode  = 2'd2;
    in_imm   = 16'h00AB;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL rstfull_after got v=%0b rdy=%0b %h want v=0 rdy=1 00000000", out_valid, in_ready, out_data);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00AB0000 || out_mode !== 2'd2) begin
      errors++;
      $display("FAIL rstfull_latency got v=%0b %0d/%h want v=1 2/00ab0000", out_valid, out_mode, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_drain got v=%0b want 0", out_valid); end
  endtask

`ifdef IMM_EXT_STATS_EN
  task automatic test_stats();
    do_reset();
    in_valid = 1'b1;
    in_mode  = 2'd0;
    in_imm   = 16'h0001;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();   // four stalled cycles
    out_ready = 1'b1;
    tick();                               // transfer 1
    in_valid = 1'b1;
    tick();                               // load
    tick();                               // transfer 2 + load
    in_valid = 1'b0;
    tick();                               // transfer 3
    checks++;
    if (stat_xfers !== 32'd3 || stat_stalls !== 32'd4) begin
      errors++;
      $display("FAIL stats_count got x=%0d s=%0d want x=3 s=4", stat_xfers, stat_stalls);
    end
    force dut.stat_xfers_q = 32'hFFFFFFFF;
    #1;
    release dut.stat_xfers_q;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (stat_xfers !== 32'd0) begin errors++; $display("FAIL stats_wrap got %h want 00000000", stat_xfers); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    #1;
    test_reset();
    test_sign_extend();
    do_reset();
    test_back_to_back();
    do_reset();
    test_stall();
    do_reset();
    test_random();
    do_reset();
    test_reset_full();
`ifdef IMM_EXT_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
